execute_stage: RTL and testbench
================================

// Module: execute_stage
// PURPOSE
//  Y86-64 execute stage, immediately downstream of decode. Holds the E pipeline register,
//  loaded from the decode outputs, and computes the ALU result e_valE. Owns the 3-bit
//  condition-code register and evaluates e_Cnd for jXX/cmovXX. Feeds the M register and
//  the forwarding/hazard paths (e_dstE/e_valE back to decode, e_Cnd to the hazard unit).
// PARAMETERS
//  CC_RESET    3'b100  {ZF,SF,OF} value at reset
//  STACK_STEP  64'd8   stack-pointer adjust for call/push (-) and ret/pop (+)
// PORTS
//  clk_i            in   1   clock, rising edge
//  rst_i            in   1   asynchronous active-high reset
//  execute_stall_i  in   1   hold the E register
//  execute_bubble_i in   1   load a nop bubble into the E register
//  set_cc_block_i   in   1   exception in M/W stage; suppress CC update
//  d_icode_i        in   4   decode icode
//  d_ifun_i         in   4   decode ifun
//  d_stat_i         in   3   decode status
//  d_valC_i         in   64  decode constant
//  d_valA_i         in   64  decode forwarded valA
//  d_valB_i         in   64  decode forwarded valB
//  d_dstE_i         in   4   decode dstE
//  d_dstM_i         in   4   decode dstM
//  d_srcA_i         in   4   decode srcA
//  d_srcB_i         in   4   decode srcB
//  E_icode_o        out  4   registered icode
//  E_stat_o         out  3   registered status
//  E_valA_o         out  64  registered valA, to M
//  E_dstM_o         out  4   registered dstM
//  E_srcA_o         out  4   registered srcA, to hazard unit
//  E_srcB_o         out  4   registered srcB, to hazard unit
//  e_valE_o         out  64  ALU result (combinational from E register and CC)
//  e_dstE_o         out  4   effective dstE; RNONE for a not-taken cmov
//  e_Cnd_o          out  1   condition result
//  cc_o             out  3   current {ZF,SF,OF}
// BEHAVIOUR
//  Reset (async, rst_i=1): E register loads the bubble (icode=INOP, ifun=0, stat=SAOK,
//   valC/valA/valB=0, dst*/src*=RNONE) and cc=CC_RESET. Resulting outputs: e_valE_o=0,
//   e_dstE_o=RNONE, e_Cnd_o=1. Reset mid-operation discards the in-flight instruction.
//  E register, per rising edge: if execute_stall_i, hold (stall wins over bubble);
//   else if execute_bubble_i, load the bubble; else load all d_* inputs. Latency: 1 cycle.
//  aluA: RRMOVQ,OPQ->valA; IRMOVQ,RMMOVQ,MRMOVQ->valC; CALL,PUSHQ->-STACK_STEP;
//   RET,POPQ->+STACK_STEP; otherwise 0.
//  aluB: RMMOVQ,MRMOVQ,OPQ,CALL,PUSHQ,RET,POPQ->valB; RRMOVQ,IRMOVQ,other->0.
//  alufun: ifun when icode=OPQ, else ADD. ADD=0: B+A; SUB=1: B-A; AND=2; XOR=3;
//   ifun>3 gives ADD. Arithmetic is 64-bit modulo 2^64; carry is dropped.
//  CC next: ZF=(valE==0); SF=valE[63]; OF: add (A63==B63)&&(R63!=A63);
//   sub (A63!=B63)&&(R63!=B63); and/xor OF=0.
//  CC write: on the edge that ends the instruction's E cycle, only if
//   E_icode=OPQ && !set_cc_block_i. Not written on a stall cycle (the instruction
//   has not completed). Not written for a bubble.
//  e_Cnd uses the CC before the current instruction's update.
//   ifun 0 always, 1 le (SF^OF)|ZF, 2 l SF^OF, 3 e ZF, 4 ne !ZF, 5 ge !(SF^OF),
//   6 g !(SF^OF)&!ZF, 7..15 = 0.
//  e_dstE_o = (E_icode==RRMOVQ && !e_Cnd) ? RNONE : E_dstE.
//  Stat and icode pass through unchanged; stage raises no new exceptions.
// TESTING
//  1. OPQ sub, valA=5, valB=5 -> e_valE=0; next cycle cc=3'b100.
//  2. OPQ add, A=B=64'h7FFF_FFFF_FFFF_FFFF -> e_valE=64'hFFFF_FFFF_FFFF_FFFE, cc=3'b011.
//  3. cmovl (ifun 2) with cc=3'b000 -> e_Cnd=0, e_dstE=4'hF; with cc=3'b010 -> e_dstE=rB.
//  4. PUSHQ valB=64'h100 -> e_valE=64'hF8; POPQ valB=64'h100 -> e_valE=64'h108; cc unchanged.
//  5. OPQ with set_cc_block_i=1 -> cc holds. Stall and bubble together -> E holds.
//     Bubble alone -> icode=INOP, e_dstE=4'hF.
//  6. Assert rst_i asynchronously mid-OPQ -> outputs return to reset values before the next
//     edge; cc=CC_RESET.

Source files
------------

// File: rtl/execute_stage.sv
// -----------------------------------------------------------------------------
// execute_stage
//
// Y86-64 execute stage. Holds the E pipeline register (loaded from decode),
// computes the ALU result e_valE, owns the {ZF,SF,OF} condition-code register
// and evaluates the jXX/cmovXX condition e_Cnd.
//
// Ports
//   clk_i, rst_i          clock (rising edge) and asynchronous active-high reset
//   execute_stall_i       hold the E register (and the CC register)
//   execute_bubble_i      load a nop bubble into E (stall has priority)
//   set_cc_block_i        an older instruction faulted; suppress the CC update
//   d_*_i                 decode-stage outputs feeding the E register
//   E_*_o                 registered fields passed on to memory / hazard unit
//   e_valE_o              ALU result (combinational)
//   e_dstE_o              effective destination, RNONE for a not-taken cmov
//   e_Cnd_o               condition result, using the CC before this instruction
//   cc_o                  current {ZF,SF,OF}
// -----------------------------------------------------------------------------
module execute_stage #(
  parameter logic [2:0]  CC_RESET   = 3'b100,
  parameter logic [63:0] STACK_STEP = 64'd8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        execute_stall_i,
  input  logic        execute_bubble_i,
  input  logic        set_cc_block_i,
  input  logic [3:0]  d_icode_i,
  input  logic [3:0]  d_ifun_i,
  input  logic [2:0]  d_stat_i,
  input  logic [63:0] d_valC_i,
  input  logic [63:0] d_valA_i,
  input  logic [63:0] d_valB_i,
  input  logic [3:0]  d_dstE_i,
  input  logic [3:0]  d_dstM_i,
  input  logic [3:0]  d_srcA_i,
  input  logic [3:0]  d_srcB_i,
  output logic [3:0]  E_icode_o,
  output logic [2:0]  E_stat_o,
  output logic [63:0] E_valA_o,
  output logic [3:0]  E_dstM_o,
  output logic [3:0]  E_srcA_o,
  output logic [3:0]  E_srcB_o,
  output logic [63:0] e_valE_o,
  output logic [3:0]  e_dstE_o,
  output logic        e_Cnd_o,
  output logic [2:0]  cc_o
);

  // Instruction codes used by this stage
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE   = 4'hF;
  localparam logic [2:0] SAOK    = 3'd1;

  // ALU function codes
  localparam logic [3:0] ALUADD  = 4'h0;
  localparam logic [3:0] ALUSUB  = 4'h1;
  localparam logic [3:0] ALUAND  = 4'h2;
  localparam logic [3:0] ALUXOR  = 4'h3;

  // ---------------------------------------------------------------------------
  // E pipeline register
  // ---------------------------------------------------------------------------
  logic [3:0]  r_E_icode;
  logic [3:0]  r_E_ifun;
  logic [2:0]  r_E_stat;
  logic [63:0] r_E_valC;
  logic [63:0] r_E_valA;
  logic [63:0] r_E_valB;
  logic [3:0]  r_E_dstE;
  logic [3:0]  r_E_dstM;
  logic [3:0]  r_E_srcA;
  logic [3:0]  r_E_srcB;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_E_icode <= INOP;
      r_E_ifun  <= 4'h0;
      r_E_stat  <= SAOK;
      r_E_valC  <= 64'd0;
      r_E_valA  <= 64'd0;
      r_E_valB  <= 64'd0;
      r_E_dstE  <= RNONE;
      r_E_dstM  <= RNONE;
      r_E_srcA  <= RNONE;
      r_E_srcB  <= RNONE;
    end else if (execute_stall_i) begin
      // Stall dominates bubble: keep the current instruction in E.
      r_E_icode <= r_E_icode;
    end else if (execute_bubble_i) begin
      r_E_icode <= INOP;
      r_E_ifun  <= 4'h0;
      r_E_stat  <= SAOK;
      r_E_valC  <= 64'd0;
      r_E_valA  <= 64'd0;
      r_E_valB  <= 64'd0;
      r_E_dstE  <= RNONE;
      r_E_dstM  <= RNONE;
      r_E_srcA  <= RNONE;
      r_E_srcB  <= RNONE;
    end else begin
      r_E_icode <= d_icode_i;
      r_E_ifun  <= d_ifun_i;
      r_E_stat  <= d_stat_i;
      r_E_valC  <= d_valC_i;
      r_E_valA  <= d_valA_i;
      r_E_valB  <= d_valB_i;
      r_E_dstE  <= d_dstE_i;
      r_E_dstM  <= d_dstM_i;
      r_E_srcA  <= d_srcA_i;
      r_E_srcB  <= d_srcB_i;
    end
  end

  // ---------------------------------------------------------------------------
  // ALU operand selection
  // ---------------------------------------------------------------------------
  logic [63:0] w_alu_a;
  logic [63:0] w_alu_b;
  logic [3:0]  w_alu_fun;

  always_comb begin
    w_alu_a = 64'd0;
    unique case (r_E_icode)
      IRRMOVQ, IOPQ:            w_alu_a = r_E_valA;
      IIRMOVQ, IRMMOVQ, IMRMOVQ: w_alu_a = r_E_valC;
      ICALL, IPUSHQ:            w_alu_a = -STACK_STEP;
      IRET, IPOPQ:              w_alu_a = STACK_STEP;
      default:                  w_alu_a = 64'd0;
    endcase
  end

  always_comb begin
    w_alu_b = 64'd0;
    unique case (r_E_icode)
      IRMMOVQ, IMRMOVQ, IOPQ, ICALL, IPUSHQ, IRET, IPOPQ: w_alu_b = r_E_valB;
      default:                                           w_alu_b = 64'd0;
    endcase
  end

  assign w_alu_fun = (r_E_icode == IOPQ) ? r_E_ifun : ALUADD;

  // ---------------------------------------------------------------------------
  // ALU and flag generation
  // ---------------------------------------------------------------------------
  logic [63:0] w_alu_res;
  logic        w_alu_of;

  always_comb begin
    w_alu_res = 64'd0;
    w_alu_of  = 1'b0;
    unique case (w_alu_fun)
      ALUSUB: begin
        w_alu_res = w_alu_b - w_alu_a;
        // Signed overflow on B-A: operands differ in sign and the result
        // sign no longer matches the minuend.
        w_alu_of  = (w_alu_a[63] != w_alu_b[63]) && (w_alu_res[63] != w_alu_b[63]);
      end
      ALUAND: begin
        w_alu_res = w_alu_b & w_alu_a;
        w_alu_of  = 1'b0;
      end
      ALUXOR: begin
        w_alu_res = w_alu_b ^ w_alu_a;
        w_alu_of  = 1'b0;
      end
      default: begin
        // ADD, and any undefined function code falls back to ADD.
        w_alu_res = w_alu_b + w_alu_a;
        w_alu_of  = (w_alu_a[63] == w_alu_b[63]) && (w_alu_res[63] != w_alu_a[63]);
      end
    endcase
  end

  logic [2:0] w_cc_next;
  assign w_cc_next = {(w_alu_res == 64'd0), w_alu_res[63], w_alu_of};

  // ---------------------------------------------------------------------------
  // Condition-code register
  // ---------------------------------------------------------------------------
  logic [2:0] r_cc;
  logic       w_cc_write;

  // Only an OPQ that actually leaves E this edge may update CC, and not when
  // an older instruction has faulted further down the pipe.
  assign w_cc_write = !execute_stall_i && (r_E_icode == IOPQ) && !set_cc_block_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cc <= CC_RESET;
    end else if (w_cc_write) begin
      r_cc <= w_cc_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Condition evaluation (uses the CC as it was before this instruction)
  // ---------------------------------------------------------------------------
  logic w_zf;
  logic w_sf;
  logic w_of;
  logic w_cnd;

  assign w_zf = r_cc[2];
  assign w_sf = r_cc[1];
  assign w_of = r_cc[0];

  always_comb begin
    w_cnd = 1'b0;
    unique case (r_E_ifun)
      4'h0:    w_cnd = 1'b1;
      4'h1:    w_cnd = (w_sf ^ w_of) | w_zf;
      4'h2:    w_cnd = w_sf ^ w_of;
      4'h3:    w_cnd = w_zf;
      4'h4:    w_cnd = !w_zf;
      4'h5:    w_cnd = !(w_sf ^ w_of);
      4'h6:    w_cnd = !(w_sf ^ w_of) && !w_zf;
      default: w_cnd = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign E_icode_o = r_E_icode;
  assign E_stat_o  = r_E_stat;
  assign E_valA_o  = r_E_valA;
  assign E_dstM_o  = r_E_dstM;
  assign E_srcA_o  = r_E_srcA;
  assign E_srcB_o  = r_E_srcB;

  assign e_valE_o  = w_alu_res;
  assign e_Cnd_o   = w_cnd;
  // A cmov whose condition fails still flows down the pipe but writes nothing.
  assign e_dstE_o  = ((r_E_icode == IRRMOVQ) && !w_cnd) ? RNONE : r_E_dstE;
  assign cc_o      = r_cc;

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;

  typedef struct {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [2:0]  stat;
    logic [63:0] valC;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
    logic        stall;
    logic        bubble;
    logic        blk;
  } stim_t;

  typedef struct {
    logic [3:0]  icode;
    logic [2:0]  stat;
    logic [63:0] valA;
    logic [3:0]  dstM;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
    logic [63:0] valE;
    logic [3:0]  dstE;
    logic        cnd;
    logic [2:0]  cc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        stall, bubble, blk;
  logic [3:0]  d_icode, d_ifun, d_dstE, d_dstM, d_srcA, d_srcB;
  logic [2:0]  d_stat;
  logic [63:0] d_valC, d_valA, d_valB;
  logic [3:0]  E_icode, E_dstM, E_srcA, E_srcB, e_dstE;
  logic [2:0]  E_stat, cc;
  logic [63:0] E_valA, e_valE;
  logic        e_Cnd;

  execute_stage dut (
    .clk_i(clk), .rst_i(rst),
    .execute_stall_i(stall), .execute_bubble_i(bubble), .set_cc_block_i(blk),
    .d_icode_i(d_icode), .d_ifun_i(d_ifun), .d_stat_i(d_stat),
    .d_valC_i(d_valC), .d_valA_i(d_valA), .d_valB_i(d_valB),
    .d_dstE_i(d_dstE), .d_dstM_i(d_dstM), .d_srcA_i(d_srcA), .d_srcB_i(d_srcB),
    .E_icode_o(E_icode), .E_stat_o(E_stat), .E_valA_o(E_valA), .E_dstM_o(E_dstM),
    .E_srcA_o(E_srcA), .E_srcB_o(E_srcB),
    .e_valE_o(e_valE), .e_dstE_o(e_dstE), .e_Cnd_o(e_Cnd), .cc_o(cc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (instruction-level semantics) ----------
  stim_t m_e;          // instruction currently held in E
  logic [2:0] m_cc;
  exp_t exp_q[$];
  event mon_ev;
  int n_cmp = 0;
  int n_err = 0;
  int n_txn = 0;

  function automatic stim_t bubble_instr();
    stim_t s;
    s.icode = 4'h1; s.ifun = 4'h0; s.stat = 3'd1;
    s.valC = 64'd0; s.valA = 64'd0; s.valB = 64'd0;
    s.dstE = 4'hF; s.dstM = 4'hF; s.srcA = 4'hF; s.srcB = 4'hF;
    s.stall = 1'b0; s.bubble = 1'b0; s.blk = 1'b0;
    return s;
  endfunction

  // What each instruction computes, stated directly per instruction.
  function automatic logic [63:0] ref_valE(stim_t e);
    case (e.icode)
      4'h2: return e.valA;                       // rrmovq / cmovXX
      4'h3: return e.valC;                       // irmovq
      4'h4, 4'h5: return e.valB + e.valC;        // effective address
      4'h6: case (e.ifun)
              4'h1: return e.valB - e.valA;
              4'h2: return e.valB & e.valA;
              4'h3: return e.valB ^ e.valA;
              default: return e.valB + e.valA;
            endcase
      4'h8, 4'hA: return e.valB - 64'd8;         // call / pushq
      4'h9, 4'hB: return e.valB + 64'd8;         // ret / popq
      default: return 64'd0;
    endcase
  endfunction

  // Flags for an OPQ: overflow means the exact 65-bit signed result
  // does not fit into 64 signed bits.
  function automatic logic [2:0] ref_flags(stim_t e);
    logic [63:0] r;
    logic [64:0] x;
    logic of;
    r = ref_valE(e);
    of = 1'b0;
    if (e.ifun == 4'h1) begin
      x = {e.valB[63], e.valB} - {e.valA[63], e.valA};
      of = x[64] ^ x[63];
    end else if (e.ifun != 4'h2 && e.ifun != 4'h3) begin
      x = {e.valB[63], e.valB} + {e.valA[63], e.valA};
      of = x[64] ^ x[63];
    end
    return {(r == 64'd0), r[63], of};
  endfunction

  function automatic logic ref_cnd(logic [3:0] fn, logic [2:0] c);
    logic zf, sf, of;
    zf = c[2]; sf = c[1]; of = c[0];
    case (fn)
      4'd0: return 1'b1;
      4'd1: return (sf != of) || zf;
      4'd2: return sf != of;
      4'd3: return zf;
      4'd4: return !zf;
      4'd5: return sf == of;
      4'd6: return (sf == of) && !zf;
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t make_exp();
    exp_t x;
    x.icode = m_e.icode; x.stat = m_e.stat; x.valA = m_e.valA;
    x.dstM = m_e.dstM; x.srcA = m_e.srcA; x.srcB = m_e.srcB;
    x.valE = ref_valE(m_e);
    x.cnd = ref_cnd(m_e.ifun, m_cc);
    x.dstE = (m_e.icode == 4'h2 && !x.cnd) ? 4'hF : m_e.dstE;
    x.cc = m_cc;
    return x;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (txn %0d, t=%0t)", name, act, expv, n_txn, $time);
    end
  endtask

  initial begin
    exp_t x;
    forever begin
      @(negedge clk or mon_ev);
      while (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        n_txn++;
        cmp("E_icode", 64'(E_icode), 64'(x.icode));
        cmp("E_stat",  64'(E_stat),  64'(x.stat));
        cmp("E_valA",  E_valA,       x.valA);
        cmp("E_dstM",  64'(E_dstM),  64'(x.dstM));
        cmp("E_srcA",  64'(E_srcA),  64'(x.srcA));
        cmp("E_srcB",  64'(E_srcB),  64'(x.srcB));
        cmp("e_valE",  e_valE,       x.valE);
        cmp("e_dstE",  64'(e_dstE),  64'(x.dstE));
        cmp("e_Cnd",   64'(e_Cnd),   64'(x.cnd));
        cmp("cc",      64'(cc),      64'(x.cc));
        $display("txn %0d icode=%h valE=%h dstE=%h cnd=%0b cc=%b", n_txn,
                 x.icode, x.valE, x.dstE, x.cnd, x.cc);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input stim_t s);
    d_icode = s.icode; d_ifun = s.ifun; d_stat = s.stat;
    d_valC = s.valC; d_valA = s.valA; d_valB = s.valB;
    d_dstE = s.dstE; d_dstM = s.dstM; d_srcA = s.srcA; d_srcB = s.srcB;
    stall = s.stall; bubble = s.bubble; blk = s.blk;
  endtask

  // One clock: drive, advance the model across the edge, then queue the
  // response expected after that edge.
  task automatic cycle(input stim_t s);
    drive(s);
    if (!s.stall) begin
      if (m_e.icode == 4'h6 && !s.blk) m_cc = ref_flags(m_e);
      m_e = s.bubble ? bubble_instr() : s;
    end
    @(posedge clk);
    #1;
    exp_q.push_back(make_exp());
  endtask

  // Asynchronous reset between edges; outputs must settle before the next edge.
  task automatic reset_mid();
    @(negedge clk);
    #1;
    rst = 1'b1;
    m_e = bubble_instr();
    m_cc = 3'b100;
    #1;
    exp_q.push_back(make_exp());
    ->mon_ev;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic stim_t mk(logic [3:0] icode, logic [3:0] ifun,
                               logic [63:0] a, logic [63:0] b, logic [63:0] c,
                               logic [3:0] dste);
    stim_t s;
    s = bubble_instr();
    s.icode = icode; s.ifun = ifun; s.valA = a; s.valB = b; s.valC = c;
    s.dstE = dste; s.dstM = 4'h5; s.srcA = 4'h2; s.srcB = 4'h3; s.stat = 3'd1;
    return s;
  endfunction

  function automatic logic [63:0] rand64();
    case ($urandom_range(0, 6))
      0: return 64'd0;
      1: return 64'h7FFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'hFFFF_FFFF_FFFF_FFFF;
      4: return 64'($urandom_range(0, 16));
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.icode = ($urandom_range(0, 3) == 0) ? 4'h6 : 4'($urandom_range(0, 15));
    s.ifun = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                         : 4'($urandom_range(0, 6));
    s.stat = 3'($urandom_range(1, 4));
    s.valC = rand64();
    s.valA = rand64();
    s.valB = ($urandom_range(0, 5) == 0) ? s.valA : rand64();
    s.dstE = 4'($urandom_range(0, 15));
    s.dstM = 4'($urandom_range(0, 15));
    s.srcA = 4'($urandom_range(0, 15));
    s.srcB = 4'($urandom_range(0, 15));
    s.stall = ($urandom_range(0, 7) == 0);
    s.bubble = ($urandom_range(0, 7) == 0);
    s.blk = ($urandom_range(0, 5) == 0);
    return s;
  endfunction

  initial begin
    stim_t s;
    rst = 1'b1;
    drive(bubble_instr());
    m_e = bubble_instr();
    m_cc = 3'b100;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(make_exp());   // reset state, checked at the next negedge
    rst = 1'b0;

    // OPQ sub 5-5 -> 0, then cc becomes ZF only
    cycle(mk(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'h3));
    cycle(mk(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF));
    // OPQ add of two max positives -> overflow to negative
    cycle(mk(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'h3));
    cycle(mk(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF));
    // 1+2 leaves cc=000; cmovl then fails
    cycle(mk(4'h6, 4'h0, 64'd1, 64'd2, 64'd0, 4'h3));
    cycle(mk(4'h2, 4'h2, 64'd55, 64'd0, 64'd0, 4'h4));
    // 1-2 leaves cc=010; cmovl then succeeds
    cycle(mk(4'h6, 4'h1, 64'd2, 64'd1, 64'd0, 4'h3));
    cycle(mk(4'h2, 4'h2, 64'd55, 64'd0, 64'd0, 4'h4));
    // stack adjust
    cycle(mk(4'hA, 4'h0, 64'd9, 64'h100, 64'd0, 4'h4));
    cycle(mk(4'hB, 4'h0, 64'd9, 64'h100, 64'd0, 4'h4));
    // OPQ xor whose CC update is blocked
    cycle(mk(4'h6, 4'h3, 64'd7, 64'd7, 64'd0, 4'h1));
    s = mk(4'h3, 4'h0, 64'd0, 64'd0, 64'h1234, 4'h6);
    s.blk = 1'b1;
    cycle(s);
    // stall together with bubble holds E
    s = mk(4'h6, 4'h0, 64'd3, 64'd4, 64'd0, 4'h2);
    s.stall = 1'b1; s.bubble = 1'b1;
    cycle(s);
    // bubble alone
    s.stall = 1'b0;
    cycle(s);
    // reset in the middle of an OPQ
    cycle(mk(4'h6, 4'h1, 64'd2, 64'd1, 64'd0, 4'h3));
    cycle(mk(4'h6, 4'h0, 64'd10, 64'd20, 64'd0, 4'h5));
    reset_mid();

    for (int i = 0; i < 400; i++) begin
      cycle(rand_stim());
      if (i % 137 == 100) reset_mid();
    end

    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
